hw_counter: RTL and testbench
=============================

Name: hw_counter

Overview:
- Memory-mapped hardware cycle counter peripheral.
- Produces `hc_OUT_data`, which the memory/load stage muxes into load results when a LW targets the counter window.
- Sits beside the data RAM on the same address/store/load bus.
- Provides:
  - a 64-bit free-running count with atomic hi/lo read via snapshot;
  - software control, preload and a low-word compare;
  - a sticky match flag with interrupt output.

Parameters:
- HC_BASE, `HARDWARE_COUNTER_ADDR: byte address of the 16-byte register window (16-byte aligned).
- CMP_RESET, 32'hFFFF_FFFF: reset value of the CMP register.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous reset, active-high.
- addr  input  32  byte address (ALU result).
- w_data  input  32  store data.
- mem_store  input  2  00 SB, 01 SH, 10 SW, 11 no store.
- mem_load  input  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 111 no load.
- hc_sel  output  1  addr[31:4] equals HC_BASE[31:4] (combinational).
- hc_OUT_data  output  32  read data for the current addr (combinational).
- hc_irq  output  1  CTRL.irq_en AND STAT.match (registered state, combinational AND).

Behaviour:
- Register map (offset = addr[3:0]; any offset not a multiple of 4 decodes as unmapped):
  - 0x0 COUNT_LO: read returns live count[31:0].
  - 0x4 COUNT_HI: read returns snap_hi.
  - 0x8 CTRL/STAT, bits:
    - [0] en (RW)
    - [1] clr (write-1 pulse, reads 0)
    - [2] irq_en (RW)
    - [8] match (sticky, write-1-clear)
    - [9] ovf (sticky, write-1-clear)
    - other bits read 0
  - 0xC CMP (RW).
- Unmapped offsets within the window read 0 and ignore writes. hc_OUT_data = 0 when hc_sel = 0.
- Writes: only mem_store = 10 (SW) with hc_sel = 1 takes effect, at posedge CLK. SB/SH to the window are ignored.
- Snapshot: at posedge, if hc_sel, offset 0x0 and mem_load = 010, then snap_hi <= count[63:32] as of that cycle (same value paired with the low word returned).
  - Software reads LO then HI for a consistent 64-bit value.
  - Loads of any other width never snapshot.
- Count update per posedge, priority high to low:
  1. RST: count=0, snap_hi=0, en=0, irq_en=0, match=0, ovf=0, CMP=CMP_RESET.
  2. CTRL write with clr=1: count <= 0. Other CTRL fields are written in the same cycle.
  3. SW to COUNT_LO or COUNT_HI: only that half is loaded; the other half is held (no increment that cycle).
  4. en=1: count <= count+1. On wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0, ovf <= 1.
  5. Otherwise hold.
- en written 1 takes effect from the next cycle: the write cycle does not increment.
- Match:
  - At posedge, if en = 1 and the next count[31:0] equals CMP, then match <= 1.
  - Set has priority over a same-cycle W1C clear of match. ovf set/clear follows the same rule.
- CMP write takes effect for comparisons from the following cycle.
- Outputs after reset: hc_OUT_data reflects decode with all state zero (CMP reads FFFF_FFFF); hc_irq = 0.
- RST during any operation discards in-progress writes and snapshot that cycle.
- Latency:
  - reads: 0 cycles (combinational from addr and state);
  - writes and snapshot: visible the cycle after the posedge.

Decomposition:
- Package hc_pkg holds:
  - offsets OFF_LO/OFF_HI/OFF_CTRL/OFF_CMP;
  - CTRL bit indices;
  - mem_store/mem_load encodings (SB, SH, SW, NO_STORE, LW, NO_LOAD), shared with the memory stage.
- One natural sub-module: hc_count64 (64-bit counter).
  - Inputs: clr, ld_lo, ld_hi, ld_data, en.
  - Outputs: count, wrap pulse.
  - Implements priority items 2–5.
- Decode, CTRL/CMP registers, snapshot and read mux live in hw_counter.

Test Plan:
- Reset, then SW 0x1 to CTRL, wait 10 cycles, LW COUNT_LO → returns 10. A second LW COUNT_LO the following cycle → 11.
- SW 0xFFFF_FFFE to COUNT_LO and 0x0000_0004 to COUNT_HI with en=1, then LW LO at count 0x4_FFFF_FFFF, then LW HI after the wrap → HI returns 4, not 5.
- Preload 64'hFFFF_FFFF_FFFF_FFFF, en=1, one cycle → count 0 and ovf=1. SW 0x201 to CTRL (W1C ovf, keep en) → ovf reads 0.
- CMP=20, CTRL=0x5, count from 0 → match=1 and hc_irq=1 when count reaches 20. W1C in the same cycle as a new match → match stays 1.
- SB 0xFF and SH 0xFFFF to CTRL → CTRL unchanged. LW at offset 0x10 (outside window) → hc_sel=0, data 0.
- CTRL write 0x3 (clr+en) while counting at 500 → next cycle count 0, then increments. RST asserted mid-count → all registers return to reset values next cycle.

Source files
------------

// File: rtl/hc_pkg.sv
// hc_pkg: shared constants for the memory-mapped hardware cycle counter.
//   - register offsets inside the 16-byte counter window
//   - CTRL/STAT bit positions
//   - mem_store / mem_load encodings, shared with the memory stage
//   - window decode helper
// The base address comes from the platform-wide HARDWARE_COUNTER_ADDR
// macro; a default is provided when the platform does not define it.

`ifndef HARDWARE_COUNTER_ADDR
`define HARDWARE_COUNTER_ADDR 32'h1000_0000
`endif

package hc_pkg;

  localparam logic [31:0] HC_BASE_DEFAULT = `HARDWARE_COUNTER_ADDR;

  // Register offsets (addr[3:0])
  localparam logic [3:0] OFF_LO   = 4'h0;
  localparam logic [3:0] OFF_HI   = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;
  localparam logic [3:0] OFF_CMP  = 4'hC;

  // CTRL/STAT bit indices
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_MATCH  = 8;
  localparam int STAT_OVF    = 9;

  // Store width encoding driven by the memory stage
  typedef enum logic [1:0] {
    SB       = 2'b00,
    SH       = 2'b01,
    SW       = 2'b10,
    NO_STORE = 2'b11
  } mem_store_e;

  // Load width encoding driven by the memory stage
  typedef enum logic [2:0] {
    LB      = 3'b000,
    LH      = 3'b001,
    LW      = 3'b010,
    LBU     = 3'b011,
    LHU     = 3'b100,
    NO_LOAD = 3'b111
  } mem_load_e;

  // True when addr falls inside the 16-byte window starting at base
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/hw_counter_if.sv
// hw_counter_if: load/store bus between the memory stage and the counter.
//   addr        byte address (ALU result)
//   w_data      store data
//   mem_store   store width (hc_pkg::mem_store_e encoding)
//   mem_load    load width (hc_pkg::mem_load_e encoding)
//   hc_sel      address hits the counter window
//   hc_OUT_data read data for the current address
//   hc_irq      match interrupt
// master = memory stage, slave = counter peripheral.

interface hw_counter_if;

  logic [31:0] addr;
  logic [31:0] w_data;
  logic [1:0]  mem_store;
  logic [2:0]  mem_load;
  logic        hc_sel;
  logic [31:0] hc_OUT_data;
  logic        hc_irq;

  modport master (
    output addr, w_data, mem_store, mem_load,
    input  hc_sel, hc_OUT_data, hc_irq
  );

  modport slave (
    input  addr, w_data, mem_store, mem_load,
    output hc_sel, hc_OUT_data, hc_irq
  );

endinterface

// File: rtl/hc_count64.sv
// hc_count64: 64-bit counter with clear, per-half load and enable.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         force count to zero (highest priority after reset)
//   ld_lo/ld_hi load ld_data into one half, other half held
//   en          increment by one
//   count       registered count
//   count_next  value count takes at the coming edge
//   wrap        combinational: the coming edge wraps all-ones to zero

module hc_count64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        ld_lo,
  input  logic        ld_hi,
  input  logic [31:0] ld_data,
  input  logic        en,
  output logic [63:0] count,
  output logic [63:0] count_next,
  output logic        wrap
);

  // Priority: clear, then half load (which suppresses the increment),
  // then increment. count_next is exported so the parent can compare
  // against the value the counter is about to take.
  always_comb begin
    count_next = count;
    wrap       = 1'b0;
    if (clr) begin
      count_next = '0;
    end else if (ld_lo) begin
      count_next = {count[63:32], ld_data};
    end else if (ld_hi) begin
      count_next = {ld_data, count[31:0]};
    end else if (en) begin
      count_next = count + 64'd1;
      wrap       = &count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/hw_counter.sv
// hw_counter: memory-mapped 64-bit cycle counter peripheral.
// Window of four word registers at HC_BASE:
//   0x0 COUNT_LO (live low word; LW here snapshots the high word)
//   0x4 COUNT_HI (snapshot high word)
//   0x8 CTRL/STAT: [0] en, [1] clr pulse, [2] irq_en, [8] match, [9] ovf
//   0xC CMP
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   bus       hw_counter_if slave modport (addr/store/load in,
//             hc_sel/hc_OUT_data/hc_irq out)

module hw_counter
  import hc_pkg::*;
#(
  parameter logic [31:0] HC_BASE   = HC_BASE_DEFAULT,
  parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic         CLK,
  input  logic         RST,
  hw_counter_if.slave  bus
);

  logic [3:0]  offset;
  logic        sel;
  logic        wr;
  logic        wr_lo;
  logic        wr_hi;
  logic        wr_ctrl;
  logic        wr_cmp;
  logic        snap_take;
  logic        clr_req;
  logic        match_set;

  logic        en;
  logic        irq_en;
  logic        match;
  logic        ovf;
  logic [31:0] cmp;
  logic [31:0] snap_hi;
  logic [31:0] stat_word;
  logic [31:0] rd_data;

  logic [63:0] count;
  logic [63:0] count_next;
  logic        wrap;

  // Address decode; only word stores land, byte/half stores are dropped.
  assign offset    = bus.addr[3:0];
  assign sel       = in_window(bus.addr, HC_BASE);
  assign wr        = sel && (bus.mem_store == SW);
  assign wr_lo     = wr && (offset == OFF_LO);
  assign wr_hi     = wr && (offset == OFF_HI);
  assign wr_ctrl   = wr && (offset == OFF_CTRL);
  assign wr_cmp    = wr && (offset == OFF_CMP);
  assign snap_take = sel && (offset == OFF_LO) && (bus.mem_load == LW);
  assign clr_req   = wr_ctrl && bus.w_data[CTRL_CLR];

  // Match uses the value the counter is about to hold and the CMP
  // currently in place, so a CMP write only affects later cycles.
  assign match_set = en && (count_next[31:0] == cmp);

  hc_count64 u_count64 (
    .clk        (CLK),
    .rst        (RST),
    .clr        (clr_req),
    .ld_lo      (wr_lo),
    .ld_hi      (wr_hi),
    .ld_data    (bus.w_data),
    .en         (en),
    .count      (count),
    .count_next (count_next),
    .wrap       (wrap)
  );

  // Control, status, compare and snapshot registers. Sticky flags give
  // the hardware set priority over a same-cycle write-1-clear so an
  // event landing on the clear is never lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      match   <= 1'b0;
      ovf     <= 1'b0;
      cmp     <= CMP_RESET;
      snap_hi <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= bus.w_data[CTRL_EN];
        irq_en <= bus.w_data[CTRL_IRQ_EN];
      end
      if (match_set) begin
        match <= 1'b1;
      end else if (wr_ctrl && bus.w_data[STAT_MATCH]) begin
        match <= 1'b0;
      end
      if (wrap) begin
        ovf <= 1'b1;
      end else if (wr_ctrl && bus.w_data[STAT_OVF]) begin
        ovf <= 1'b0;
      end
      if (wr_cmp) begin
        cmp <= bus.w_data;
      end
      if (snap_take) begin
        snap_hi <= count[63:32];
      end
    end
  end

  // CTRL/STAT read view; clr always reads back as zero.
  always_comb begin
    stat_word              = '0;
    stat_word[CTRL_EN]     = en;
    stat_word[CTRL_IRQ_EN] = irq_en;
    stat_word[STAT_MATCH]  = match;
    stat_word[STAT_OVF]    = ovf;
  end

  // Read mux; unaligned offsets and out-of-window addresses read zero.
  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (offset)
        OFF_LO:   rd_data = count[31:0];
        OFF_HI:   rd_data = snap_hi;
        OFF_CTRL: rd_data = stat_word;
        OFF_CMP:  rd_data = cmp;
        default:  rd_data = '0;
      endcase
    end
  end

  assign bus.hc_sel      = sel;
  assign bus.hc_OUT_data = rd_data;
  assign bus.hc_irq      = irq_en & match;

endmodule

// File: tb/tb_hw_counter.sv
// tb_hw_counter: directed self-checking bench for hw_counter.
// Inputs change 1 time unit after a rising edge; outputs are sampled a
// further unit later, well away from the next edge.

module tb_hw_counter;
  import hc_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  hw_counter_if bus ();

  hw_counter #(
    .HC_BASE   (BASE),
    .CMP_RESET (32'hFFFF_FFFF)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and step just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word store to an offset in the window, taking one edge
  task automatic sw(input logic [31:0] off, input logic [31:0] data);
    bus.addr      = BASE + off;
    bus.w_data    = data;
    bus.mem_store = SW;
    bus.mem_load  = NO_LOAD;
    tick();
    bus.mem_store = NO_STORE;
  endtask

  // Present a read address/width and let the combinational path settle
  task automatic peek(input logic [31:0] off, input logic [2:0] ld);
    bus.addr      = BASE + off;
    bus.mem_store = NO_STORE;
    bus.mem_load  = ld;
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.mem_store = NO_STORE;
    bus.mem_load  = NO_LOAD;
    bus.addr      = BASE;
    bus.w_data    = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_lo: got %h want %h", bus.hc_OUT_data, 32'h0); end
    checks++; if (bus.hc_sel !== 1'b1) begin fails++; $display("[TB] FAIL rst_sel: got %b want 1", bus.hc_sel); end
    peek(32'h4, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_hi: got %h want %h", bus.hc_OUT_data, 32'h0); end
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_ctrl: got %h want %h", bus.hc_OUT_data, 32'h0); end
    peek(32'hC, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL rst_cmp: got %h want %h", bus.hc_OUT_data, 32'hFFFF_FFFF); end
    checks++; if (bus.hc_irq !== 1'b0) begin fails++; $display("[TB] FAIL rst_irq: got %b want 0", bus.hc_irq); end
  endtask

  task automatic test_count();
    do_reset();
    sw(32'h8, 32'h1);
    repeat (10) tick();
    peek(32'h0, LW);
    checks++; if (bus.hc_OUT_data !== 32'd10) begin fails++; $display("[TB] FAIL count_10: got %0d want 10", bus.hc_OUT_data); end
    tick();
    checks++; if (bus.hc_OUT_data !== 32'd11) begin fails++; $display("[TB] FAIL count_11: got %0d want 11", bus.hc_OUT_data); end
    bus.mem_load = NO_LOAD;
  endtask

  task automatic test_snapshot();
    do_reset();
    sw(32'h8, 32'h1);
    sw(32'h0, 32'hFFFF_FFFE);
    sw(32'h4, 32'h0000_0004);
    tick();
    peek(32'h0, LW);
    checks++; if (bus.hc_OUT_data !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL snap_lo: got %h want %h", bus.hc_OUT_data, 32'hFFFF_FFFF); end
    tick();
    peek(32'h4, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h4) begin fails++; $display("[TB] FAIL snap_hi: got %h want %h", bus.hc_OUT_data, 32'h4); end
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL snap_lo_wrapped: got %h want %h", bus.hc_OUT_data, 32'h0); end
  endtask

  task automatic test_overflow();
    do_reset();
    sw(32'h0, 32'hFFFF_FFFF);
    sw(32'h4, 32'hFFFF_FFFF);
    sw(32'h8, 32'h1);
    tick();
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL ovf_lo: got %h want %h", bus.hc_OUT_data, 32'h0); end
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h201) begin fails++; $display("[TB] FAIL ovf_set: got %h want %h", bus.hc_OUT_data, 32'h201); end
    sw(32'h8, 32'h201);
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h001) begin fails++; $display("[TB] FAIL ovf_clr: got %h want %h", bus.hc_OUT_data, 32'h001); end
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h1) begin fails++; $display("[TB] FAIL ovf_lo_after: got %h want %h", bus.hc_OUT_data, 32'h1); end
  endtask

  task automatic test_match();
    do_reset();
    sw(32'hC, 32'd20);
    sw(32'h8, 32'h5);
    repeat (19) tick();
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h005) begin fails++; $display("[TB] FAIL match_early: got %h want %h", bus.hc_OUT_data, 32'h005); end
    checks++; if (bus.hc_irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_early: got %b want 0", bus.hc_irq); end
    tick();
    checks++; if (bus.hc_OUT_data !== 32'h105) begin fails++; $display("[TB] FAIL match_set: got %h want %h", bus.hc_OUT_data, 32'h105); end
    checks++; if (bus.hc_irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_set: got %b want 1", bus.hc_irq); end
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'd20) begin fails++; $display("[TB] FAIL match_count: got %0d want 20", bus.hc_OUT_data); end
    sw(32'h8, 32'h105);
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h005) begin fails++; $display("[TB] FAIL match_w1c: got %h want %h", bus.hc_OUT_data, 32'h005); end
    checks++; if (bus.hc_irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_w1c: got %b want 0", bus.hc_irq); end
    sw(32'hC, 32'd24);
    tick();
    sw(32'h8, 32'h105);
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h105) begin fails++; $display("[TB] FAIL match_set_wins: got %h want %h", bus.hc_OUT_data, 32'h105); end
    checks++; if (bus.hc_irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_set_wins: got %b want 1", bus.hc_irq); end
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'd24) begin fails++; $display("[TB] FAIL match2_count: got %0d want 24", bus.hc_OUT_data); end
  endtask

  task automatic test_decode();
    do_reset();
    bus.addr      = BASE + 32'h8;
    bus.w_data    = 32'hFF;
    bus.mem_store = SB;
    tick();
    bus.w_data    = 32'hFFFF;
    bus.mem_store = SH;
    tick();
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL sb_sh_ctrl: got %h want %h", bus.hc_OUT_data, 32'h0); end
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL sb_sh_count: got %h want %h", bus.hc_OUT_data, 32'h0); end
    sw(32'h9, 32'h1);
    tick();
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL unaligned_wr: got %h want %h", bus.hc_OUT_data, 32'h0); end
    peek(32'hD, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL unaligned_rd: got %h want %h", bus.hc_OUT_data, 32'h0); end
    peek(32'h10, LW);
    checks++; if (bus.hc_sel !== 1'b0) begin fails++; $display("[TB] FAIL outside_sel: got %b want 0", bus.hc_sel); end
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL outside_data: got %h want %h", bus.hc_OUT_data, 32'h0); end
    bus.mem_load = NO_LOAD;
  endtask

  task automatic test_clear_and_reset();
    do_reset();
    sw(32'h0, 32'd500);
    sw(32'h8, 32'h1);
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'd500) begin fails++; $display("[TB] FAIL clr_pre: got %0d want 500", bus.hc_OUT_data); end
    sw(32'h8, 32'h3);
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'd0) begin fails++; $display("[TB] FAIL clr_zero: got %0d want 0", bus.hc_OUT_data); end
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h1) begin fails++; $display("[TB] FAIL clr_ctrl: got %h want %h", bus.hc_OUT_data, 32'h1); end
    tick();
    tick();
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'd2) begin fails++; $display("[TB] FAIL clr_inc: got %0d want 2", bus.hc_OUT_data); end
    sw(32'h4, 32'd7);
    peek(32'h0, LW);
    tick();
    peek(32'h4, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'd7) begin fails++; $display("[TB] FAIL pre_rst_hi: got %h want %h", bus.hc_OUT_data, 32'h7); end
    sw(32'hC, 32'h1234);
    rst           = 1'b1;
    bus.addr      = BASE + 32'h8;
    bus.w_data    = 32'h5;
    bus.mem_store = SW;
    tick();
    rst           = 1'b0;
    bus.mem_store = NO_STORE;
    peek(32'h8, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL mid_rst_ctrl: got %h want %h", bus.hc_OUT_data, 32'h0); end
    checks++; if (bus.hc_irq !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_irq: got %b want 0", bus.hc_irq); end
    peek(32'hC, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL mid_rst_cmp: got %h want %h", bus.hc_OUT_data, 32'hFFFF_FFFF); end
    peek(32'h4, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL mid_rst_hi: got %h want %h", bus.hc_OUT_data, 32'h0); end
    tick();
    peek(32'h0, NO_LOAD);
    checks++; if (bus.hc_OUT_data !== 32'h0) begin fails++; $display("[TB] FAIL mid_rst_lo: got %h want %h", bus.hc_OUT_data, 32'h0); end
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.addr      = BASE;
    bus.w_data    = '0;
    bus.mem_store = NO_STORE;
    bus.mem_load  = NO_LOAD;
    test_reset();
    test_count();
    test_snapshot();
    test_overflow();
    test_match();
    test_decode();
    test_clear_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
